// File: rtl/mem_return_pkg.sv
// Shared types for the memory return router: the issue kind carried by each
// in-flight read tag and the tag itself.
package mem_return_pkg;

   typedef enum logic [2:0] {
      K_NONE,
      K_RELOAD,
      K_DSTACK,
      K_CONVEYOR,
      K_STREAM
   } ret_kind_t;

   typedef struct packed {
      ret_kind_t  kind;
      logic [1:0] choice;
   } ret_tag_t;

   localparam ret_tag_t TAG_NONE = '{kind: K_NONE, choice: 2'd0};

   // Priority encode of the issue flags: reload > dstack > conveyor > stream.
   function automatic ret_kind_t encode_kind(input logic reload, input logic dstack,
                                             input logic conveyor, input logic stream);
      if (reload)        return K_RELOAD;
      else if (dstack)   return K_DSTACK;
      else if (conveyor) return K_CONVEYOR;
      else if (stream)   return K_STREAM;
      else               return K_NONE;
   endfunction

endpackage

// File: rtl/mem_return_router_if.sv
// Bundle of the mem_control issue flags, memory read data and all routed
// outputs of the return router.
interface mem_return_router_if #(parameter int WORD_WIDTH = 32);

   logic                  reload;
   logic [1:0]            choice;
   logic                  conveyor_memload;
   logic                  dstack_memload;
   logic                  stream_read;
   logic [WORD_WIDTH-1:0] read_value;
   logic                  stream_ready;

   logic                  conveyor_memload_last;
   logic                  dstack_memload_last;
   logic                  dc_reload_valid;
   logic [1:0]            dc_reload_choice;
   logic [WORD_WIDTH-1:0] dc_reload_value;
   logic                  dstack_push_valid;
   logic                  conveyor_valid;
   logic [WORD_WIDTH-1:0] route_value;
   logic                  stream_out_valid;
   logic [WORD_WIDTH-1:0] stream_out_value;
   logic                  stream_stall;
   logic                  pending;
   logic                  protocol_error;

   modport master (
      output reload, choice, conveyor_memload, dstack_memload, stream_read,
             read_value, stream_ready,
      input  conveyor_memload_last, dstack_memload_last, dc_reload_valid,
             dc_reload_choice, dc_reload_value, dstack_push_valid, conveyor_valid,
             route_value, stream_out_valid, stream_out_value, stream_stall,
             pending, protocol_error
   );

   modport slave (
      input  reload, choice, conveyor_memload, dstack_memload, stream_read,
             read_value, stream_ready,
      output conveyor_memload_last, dstack_memload_last, dc_reload_valid,
             dc_reload_choice, dc_reload_value, dstack_push_valid, conveyor_valid,
             route_value, stream_out_valid, stream_out_value, stream_stall,
             pending, protocol_error
   );

endinterface

// File: rtl/mem_return_stream_fifo.sv
// First-word-fall-through buffer for stream-out read data. The head reads as
// zero while empty so the stream output is quiet. Overflow is prevented
// upstream by the stall logic, so push into a full buffer is not handled.
module mem_return_stream_fifo #(
   parameter int WORD_WIDTH   = 32,
   parameter int STREAM_DEPTH = 2,
   localparam int PW = (STREAM_DEPTH > 1) ? $clog2(STREAM_DEPTH) : 1,
   localparam int CW = $clog2(STREAM_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  push,
   input  logic [WORD_WIDTH-1:0] push_value,
   input  logic                  pop,
   output logic [WORD_WIDTH-1:0] head,
   output logic [CW-1:0]         count
);

   logic [WORD_WIDTH-1:0] mem [STREAM_DEPTH];
   logic [PW-1:0]         wr_ptr, rd_ptr;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(STREAM_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Storage and pointers; push and pop may both fire in one cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < STREAM_DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_value;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
         if (push && !pop)      count <= count + 1'b1;
         else if (!push && pop) count <= count - 1'b1;
      end
   end

   // Fall-through head, zero when empty.
   always_comb begin
      head = '0;
      if (count != '0) head = mem[rd_ptr];
   end

endmodule

// File: rtl/mem_return_router.sv
// Tracks each main-memory read issued by mem_control through a tag pipeline
// that matches the memory read latency, and routes the returning word to the
// dc reload, dstack push, conveyor or stream-out buffer.
module mem_return_router
   import mem_return_pkg::*;
#(
   parameter int WORD_WIDTH   = 32,
   parameter int READ_LATENCY = 1,
   parameter int STREAM_DEPTH = 2
) (
   input logic              clk,
   input logic              reset_n,
   mem_return_router_if.slave bus
);

   localparam int CW = $clog2(STREAM_DEPTH + 1);
   localparam int IW = $clog2(READ_LATENCY + 1);

   ret_tag_t              issue_tag;
   logic                  multi_issue;
   ret_tag_t              tag_pipe [READ_LATENCY];
   ret_tag_t              head_tag;
   logic                  tag_busy;
   logic [IW-1:0]         stream_inflight;
   logic                  fifo_push, fifo_pop;
   logic [WORD_WIDTH-1:0] fifo_head;
   logic [CW-1:0]         fifo_count;

   // Encode this cycle's issue into a tag and flag overlapping issue flags.
   always_comb begin
      issue_tag.kind   = encode_kind(bus.reload, bus.dstack_memload,
                                     bus.conveyor_memload, bus.stream_read);
      issue_tag.choice = bus.choice;
      multi_issue = (bus.reload && (bus.dstack_memload || bus.conveyor_memload || bus.stream_read))
                 || (bus.dstack_memload && (bus.conveyor_memload || bus.stream_read))
                 || (bus.conveyor_memload && bus.stream_read);
   end

   // Tag shift pipeline: stage READ_LATENCY-1 lines up with read_value.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < READ_LATENCY; i++) tag_pipe[i] <= TAG_NONE;
      end else begin
         tag_pipe[0] <= issue_tag;
         for (int i = 1; i < READ_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
      end
   end

   // Feedback registers for mem_control and the registered error pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.conveyor_memload_last <= 1'b0;
         bus.dstack_memload_last   <= 1'b0;
         bus.protocol_error        <= 1'b0;
      end else begin
         bus.conveyor_memload_last <= bus.conveyor_memload;
         bus.dstack_memload_last   <= bus.dstack_memload;
         bus.protocol_error        <= multi_issue;
      end
   end

   // Occupancy of the pipeline: any live tag, and how many are stream reads.
   always_comb begin
      tag_busy        = 1'b0;
      stream_inflight = '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
         if (tag_pipe[i].kind != K_NONE)   tag_busy = 1'b1;
         if (tag_pipe[i].kind == K_STREAM) stream_inflight = stream_inflight + 1'b1;
      end
   end

   // Zero-latency routing of read_value by the head tag; data gated by its valid.
   always_comb begin
      head_tag              = tag_pipe[READ_LATENCY-1];
      bus.dc_reload_valid   = 1'b0;
      bus.dc_reload_choice  = '0;
      bus.dc_reload_value   = '0;
      bus.dstack_push_valid = 1'b0;
      bus.conveyor_valid    = 1'b0;
      bus.route_value       = '0;
      fifo_push             = 1'b0;
      case (head_tag.kind)
         K_RELOAD: begin
            bus.dc_reload_valid  = 1'b1;
            bus.dc_reload_choice = head_tag.choice;
            bus.dc_reload_value  = bus.read_value;
         end
         K_DSTACK: begin
            bus.dstack_push_valid = 1'b1;
            bus.route_value       = bus.read_value;
         end
         K_CONVEYOR: begin
            bus.conveyor_valid = 1'b1;
            bus.route_value    = bus.read_value;
         end
         K_STREAM: fifo_push = 1'b1;
         default:  ;
      endcase
   end

   mem_return_stream_fifo #(
      .WORD_WIDTH   (WORD_WIDTH),
      .STREAM_DEPTH (STREAM_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset_n    (reset_n),
      .push       (fifo_push),
      .push_value (bus.read_value),
      .pop        (fifo_pop),
      .head       (fifo_head),
      .count      (fifo_count)
   );

   // Stream side: stall counts words held plus stream reads still in flight,
   // so a granted read always finds room when its data returns.
   always_comb begin
      bus.stream_out_valid = (fifo_count != '0);
      bus.stream_out_value = fifo_head;
      fifo_pop             = bus.stream_out_valid && bus.stream_ready;
      bus.stream_stall     = (32'(fifo_count) + 32'(stream_inflight)) >= 32'(STREAM_DEPTH);
      bus.pending          = tag_busy || (fifo_count != '0);
   end

endmodule

// File: tb/tb_mem_return_router.sv
// Directed bench for mem_return_router: one instance at READ_LATENCY=1 and one
// at READ_LATENCY=3, both with STREAM_DEPTH=2, sharing clock and reset.
module tb_mem_return_router;

   logic clk = 1'b0;
   logic reset_n;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   mem_return_router_if #(.WORD_WIDTH(32)) bus_a ();
   mem_return_router_if #(.WORD_WIDTH(32)) bus_b ();

   mem_return_router #(.WORD_WIDTH(32), .READ_LATENCY(1), .STREAM_DEPTH(2)) u_lat1 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_a)
   );

   mem_return_router #(.WORD_WIDTH(32), .READ_LATENCY(3), .STREAM_DEPTH(2)) u_lat3 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_b)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      bus_a.reload = 0; bus_a.choice = 0; bus_a.conveyor_memload = 0;
      bus_a.dstack_memload = 0; bus_a.stream_read = 0; bus_a.read_value = 0;
      bus_a.stream_ready = 0;
      bus_b.reload = 0; bus_b.choice = 0; bus_b.conveyor_memload = 0;
      bus_b.dstack_memload = 0; bus_b.stream_read = 0; bus_b.read_value = 0;
      bus_b.stream_ready = 0;
   endtask

   initial begin
      reset_n = 1'b0;
      idle();

      // reset state
      @(negedge clk); #1;
      chk("rst_pending", bus_a.pending, 0);
      chk("rst_stall",   bus_a.stream_stall, 0);
      chk("rst_ovalid",  bus_b.stream_out_valid, 0);
      @(negedge clk); reset_n = 1'b1;

      // LAT=1 reload to dc 2
      @(negedge clk); bus_a.reload = 1; bus_a.choice = 2;
      @(negedge clk); bus_a.reload = 0; bus_a.choice = 0; bus_a.read_value = 32'hDEAD_BEEF; #1;
      chk("rl_valid",  bus_a.dc_reload_valid, 1);
      chk("rl_choice", bus_a.dc_reload_choice, 2);
      chk("rl_value",  bus_a.dc_reload_value, 32'hDEAD_BEEF);
      chk("rl_pend",   bus_a.pending, 1);
      @(negedge clk); #1;
      chk("rl_once",   bus_a.dc_reload_valid, 0);
      chk("rl_idle",   bus_a.pending, 0);

      // reload and dstack together: reload wins, error pulse next cycle
      @(negedge clk); bus_a.reload = 1; bus_a.choice = 1; bus_a.dstack_memload = 1; #1;
      chk("pe_pre", bus_a.protocol_error, 0);
      @(negedge clk);
      bus_a.reload = 0; bus_a.choice = 0; bus_a.dstack_memload = 0;
      bus_a.read_value = 32'hCAFE_F00D; #1;
      chk("pe_pulse",     bus_a.protocol_error, 1);
      chk("pe_rl_valid",  bus_a.dc_reload_valid, 1);
      chk("pe_rl_choice", bus_a.dc_reload_choice, 1);
      chk("pe_rl_value",  bus_a.dc_reload_value, 32'hCAFE_F00D);
      chk("pe_no_push",   bus_a.dstack_push_valid, 0);
      chk("pe_dlast",     bus_a.dstack_memload_last, 1);
      @(negedge clk); bus_a.read_value = 0; #1;
      chk("pe_clear", bus_a.protocol_error, 0);

      // LAT=3 back-to-back dstack, conveyor, dstack
      @(negedge clk); bus_b.dstack_memload = 1;
      @(negedge clk); bus_b.dstack_memload = 0; bus_b.conveyor_memload = 1; #1;
      chk("b2b_dlast_c1", bus_b.dstack_memload_last, 1);
      @(negedge clk); bus_b.conveyor_memload = 0; bus_b.dstack_memload = 1; #1;
      chk("b2b_dlast_c2", bus_b.dstack_memload_last, 0);
      chk("b2b_clast_c2", bus_b.conveyor_memload_last, 1);
      @(negedge clk); bus_b.dstack_memload = 0; bus_b.read_value = 32'h111; #1;
      chk("b2b_dlast_c3", bus_b.dstack_memload_last, 1);
      chk("b2b_push_c3",  bus_b.dstack_push_valid, 1);
      chk("b2b_conv_c3",  bus_b.conveyor_valid, 0);
      chk("b2b_val_c3",   bus_b.route_value, 32'h111);
      @(negedge clk); bus_b.read_value = 32'h222; #1;
      chk("b2b_conv_c4",  bus_b.conveyor_valid, 1);
      chk("b2b_push_c4",  bus_b.dstack_push_valid, 0);
      chk("b2b_val_c4",   bus_b.route_value, 32'h222);
      @(negedge clk); bus_b.read_value = 32'h333; #1;
      chk("b2b_push_c5",  bus_b.dstack_push_valid, 1);
      chk("b2b_val_c5",   bus_b.route_value, 32'h333);
      @(negedge clk); bus_b.read_value = 0; #1;
      chk("b2b_done", {bus_b.dstack_push_valid, bus_b.conveyor_valid, bus_b.pending}, 0);

      // LAT=1 stream: fill with ready low, then drain in order
      @(negedge clk); bus_a.stream_read = 1; #1;
      chk("st_stall_s0", bus_a.stream_stall, 0);
      @(negedge clk); bus_a.read_value = 32'h1111_0001; #1;
      chk("st_stall_s1", bus_a.stream_stall, 0);
      @(negedge clk); bus_a.stream_read = 0; bus_a.read_value = 32'h1111_0002; #1;
      chk("st_stall_s2", bus_a.stream_stall, 1);
      chk("st_ovalid_s2", bus_a.stream_out_valid, 1);
      chk("st_head_s2", bus_a.stream_out_value, 32'h1111_0001);
      @(negedge clk); bus_a.read_value = 0; bus_a.stream_ready = 1; #1;
      chk("st_stall_s3", bus_a.stream_stall, 1);
      chk("st_head_s3", bus_a.stream_out_value, 32'h1111_0001);
      @(negedge clk); bus_a.stream_ready = 0; bus_a.stream_read = 1; #1;
      chk("st_stall_s4", bus_a.stream_stall, 0);
      chk("st_head_s4", bus_a.stream_out_value, 32'h1111_0002);
      // push of word 3 and pop of word 2 on the same edge
      @(negedge clk); bus_a.stream_read = 0; bus_a.read_value = 32'h1111_0003; bus_a.stream_ready = 1; #1;
      chk("pp_head_pre", bus_a.stream_out_value, 32'h1111_0002);
      chk("pp_stall_pre", bus_a.stream_stall, 1);
      @(negedge clk); bus_a.read_value = 0; #1;
      chk("pp_ovalid", bus_a.stream_out_valid, 1);
      chk("pp_head", bus_a.stream_out_value, 32'h1111_0003);
      chk("pp_stall", bus_a.stream_stall, 0);
      @(negedge clk); bus_a.stream_ready = 0; #1;
      chk("pp_empty", bus_a.stream_out_valid, 0);
      chk("pp_idle", bus_a.pending, 0);

      // LAT=3: fill all stages and two stream words, then reset mid-flight
      @(negedge clk); bus_b.stream_read = 1;
      @(negedge clk); #1;
      chk("mf_stall_c1", bus_b.stream_stall, 0);
      @(negedge clk); bus_b.stream_read = 0; bus_b.reload = 1; bus_b.choice = 3;
      @(negedge clk); bus_b.reload = 0; bus_b.choice = 0; bus_b.dstack_memload = 1;
      bus_b.read_value = 32'hAAAA_AAAA;
      @(negedge clk); bus_b.dstack_memload = 0; bus_b.conveyor_memload = 1;
      bus_b.read_value = 32'hBBBB_BBBB;
      @(negedge clk); bus_b.conveyor_memload = 0; bus_b.read_value = 32'hCCCC_CCCC; #1;
      chk("mf_ovalid", bus_b.stream_out_valid, 1);
      chk("mf_head",   bus_b.stream_out_value, 32'hAAAA_AAAA);
      chk("mf_stall",  bus_b.stream_stall, 1);
      chk("mf_rl",     {bus_b.dc_reload_valid, bus_b.dc_reload_choice}, 3'b111);
      chk("mf_rl_val", bus_b.dc_reload_value, 32'hCCCC_CCCC);
      chk("mf_clast",  bus_b.conveyor_memload_last, 1);
      #1 reset_n = 1'b0; #1;
      chk("mf_rst_valids", {bus_b.dc_reload_valid, bus_b.dstack_push_valid,
                            bus_b.conveyor_valid, bus_b.stream_out_valid}, 0);
      chk("mf_rst_data", {bus_b.dc_reload_value, bus_b.route_value}, 0);
      chk("mf_rst_out",  bus_b.stream_out_value, 0);
      chk("mf_rst_flags", {bus_b.dc_reload_choice, bus_b.stream_stall, bus_b.pending,
                           bus_b.protocol_error, bus_b.conveyor_memload_last,
                           bus_b.dstack_memload_last}, 0);
      @(negedge clk); reset_n = 1'b1; bus_b.read_value = 32'h5555_5555;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         chk("mf_quiet", {bus_b.dc_reload_valid, bus_b.dstack_push_valid,
                          bus_b.conveyor_valid, bus_b.stream_out_valid, bus_b.pending}, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
